// File: rtl/stack_pkg.sv
// Shared op-code definitions for the parametrised stack.
package stack_pkg;

    typedef logic [2:0] op_t;

    localparam op_t OP_NOP     = 3'd0;
    localparam op_t OP_PUSH    = 3'd1;
    localparam op_t OP_POP     = 3'd2;
    localparam op_t OP_REPLACE = 3'd3;
    localparam op_t OP_DUP     = 3'd4;
    localparam op_t OP_SWAP    = 3'd5;

endpackage

// File: rtl/stack_regfile.sv
// Stack storage: two synchronous write ports (SWAP writes two entries at once)
// and two asynchronous read ports feeding tos/nos.
module stack_regfile
    import stack_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we_a,
    input  logic [AW-1:0]         addr_a,
    input  logic [DATA_WIDTH-1:0] wdata_a,
    input  logic                  we_b,
    input  logic [AW-1:0]         addr_b,
    input  logic [DATA_WIDTH-1:0] wdata_b,
    input  logic [AW-1:0]         raddr_a,
    output logic [DATA_WIDTH-1:0] rdata_a,
    input  logic [AW-1:0]         raddr_b,
    output logic [DATA_WIDTH-1:0] rdata_b
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Contents are never reset; validity is tracked by the owner's count.
    always_ff @(posedge clk) begin
        if (we_a) mem[addr_a] <= wdata_a;
        if (we_b) mem[addr_b] <= wdata_b;
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/param_stack.sv
// Opcode-driven LIFO exposing top and next-on-stack operands, with element
// count and one-cycle overflow/underflow pulses.
module param_stack
    import stack_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int CNT_BITS   = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [DATA_WIDTH-1:0] tos,
    output logic [DATA_WIDTH-1:0] nos,
    output logic [CNT_BITS-1:0]   count,
    output logic                  empty,
    output logic                  full,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int AW = $clog2(DEPTH);

    op_t                   op_dec;
    logic [AW-1:0]         top_idx;
    logic [AW-1:0]         nos_idx;
    logic [AW-1:0]         free_idx;
    logic [DATA_WIDTH-1:0] rd_top;
    logic [DATA_WIDTH-1:0] rd_nos;

    logic                  we_a;
    logic                  we_b;
    logic [AW-1:0]         addr_a;
    logic [AW-1:0]         addr_b;
    logic [DATA_WIDTH-1:0] wdata_a;
    logic [DATA_WIDTH-1:0] wdata_b;
    logic [CNT_BITS-1:0]   count_next;
    logic                  load_out;
    logic                  ovf_next;
    logic                  unf_next;

    assign op_dec = op_t'(op);

    // Indices are only meaningful when the guarding count condition holds.
    assign top_idx  = AW'(count - CNT_BITS'(1));
    assign nos_idx  = AW'(count - CNT_BITS'(2));
    assign free_idx = AW'(count);

    assign empty = (count == '0);
    assign full  = (count == CNT_BITS'(DEPTH));
    assign tos   = empty ? '0 : rd_top;
    assign nos   = (count >= CNT_BITS'(2)) ? rd_nos : '0;

    stack_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (AW)
    ) u_regfile (
        .clk     (clk),
        .we_a    (we_a),
        .addr_a  (addr_a),
        .wdata_a (wdata_a),
        .we_b    (we_b),
        .addr_b  (addr_b),
        .wdata_b (wdata_b),
        .raddr_a (top_idx),
        .rdata_a (rd_top),
        .raddr_b (nos_idx),
        .rdata_b (rd_nos)
    );

    always_comb begin
        we_a       = 1'b0;
        we_b       = 1'b0;
        addr_a     = free_idx;
        addr_b     = nos_idx;
        wdata_a    = data_in;
        wdata_b    = rd_top;
        count_next = count;
        load_out   = 1'b0;
        ovf_next   = 1'b0;
        unf_next   = 1'b0;

        case (op_dec)
            OP_NOP: ;
            OP_PUSH: begin
                if (full) begin
                    ovf_next = 1'b1;
                end else begin
                    we_a       = 1'b1;
                    count_next = count + CNT_BITS'(1);
                end
            end
            OP_POP: begin
                if (empty) begin
                    unf_next = 1'b1;
                end else begin
                    load_out   = 1'b1;
                    count_next = count - CNT_BITS'(1);
                end
            end
            OP_REPLACE: begin
                // On an empty stack this degenerates to a plain push.
                we_a = 1'b1;
                if (empty) begin
                    addr_a     = '0;
                    count_next = CNT_BITS'(1);
                end else begin
                    addr_a   = top_idx;
                    load_out = 1'b1;
                end
            end
            OP_DUP: begin
                if (empty) begin
                    unf_next = 1'b1;
                end else if (full) begin
                    ovf_next = 1'b1;
                end else begin
                    we_a       = 1'b1;
                    wdata_a    = rd_top;
                    count_next = count + CNT_BITS'(1);
                end
            end
            OP_SWAP: begin
                if (count < CNT_BITS'(2)) begin
                    unf_next = 1'b1;
                end else begin
                    we_a    = 1'b1;
                    addr_a  = top_idx;
                    wdata_a = rd_nos;
                    we_b    = 1'b1;
                    addr_b  = nos_idx;
                    wdata_b = rd_top;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count     <= '0;
            data_out  <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            count     <= count_next;
            overflow  <= ovf_next;
            underflow <= unf_next;
            if (load_out) data_out <= rd_top;
        end
    end

endmodule

// File: tb/tb_param_stack.sv
// Directed bench for param_stack at DEPTH=4, DATA_WIDTH=32 with hand-computed
// expectations for every operation and its error cases.
module tb_param_stack;

    localparam int DW = 32;
    localparam int DEPTH = 4;
    localparam int CB = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [2:0]    op = 3'd0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] data_out;
    logic [DW-1:0] tos;
    logic [DW-1:0] nos;
    logic [CB-1:0] count;
    logic          empty;
    logic          full;
    logic          overflow;
    logic          underflow;

    int errors = 0;
    int checks = 0;

    param_stack #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .op        (op),
        .data_in   (data_in),
        .data_out  (data_out),
        .tos       (tos),
        .nos       (nos),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [DW-1:0] actual,
                               input logic [DW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drive one op for a single clock edge, then sample 1 time unit later.
    task automatic applyStimulus(input logic [2:0] o, input logic [DW-1:0] d);
        op      = o;
        data_in = d;
        @(posedge clk);
        #1;
        op      = 3'd0;
        data_in = '0;
    endtask

    task automatic checkState(input string tag, input int c, input logic [DW-1:0] t,
                              input logic [DW-1:0] n, input logic [DW-1:0] dout,
                              input logic ovf, input logic unf);
        checkOutput({tag, ".count"}, DW'(count), DW'(c));
        checkOutput({tag, ".tos"}, tos, t);
        checkOutput({tag, ".nos"}, nos, n);
        checkOutput({tag, ".data_out"}, data_out, dout);
        checkOutput({tag, ".empty"}, DW'(empty), DW'(c == 0));
        checkOutput({tag, ".full"}, DW'(full), DW'(c == DEPTH));
        checkOutput({tag, ".overflow"}, DW'(overflow), DW'(ovf));
        checkOutput({tag, ".underflow"}, DW'(underflow), DW'(unf));
    endtask

    initial begin
        $display("[TB] starting param_stack directed test");
        reset = 1'b1;
        applyStimulus(3'd0, '0);
        applyStimulus(3'd0, '0);
        reset = 1'b0;
        checkState("reset", 0, 0, 0, 0, 0, 0);

        applyStimulus(3'd1, 32'h11);
        checkState("push1", 1, 32'h11, 0, 0, 0, 0);
        applyStimulus(3'd1, 32'h22);
        applyStimulus(3'd1, 32'h33);
        applyStimulus(3'd1, 32'h44);
        checkState("push4", 4, 32'h44, 32'h33, 0, 0, 0);
        applyStimulus(3'd1, 32'h55);
        checkState("push_ovf", 4, 32'h44, 32'h33, 0, 1, 0);
        applyStimulus(3'd0, '0);
        checkState("ovf_clear", 4, 32'h44, 32'h33, 0, 0, 0);

        applyStimulus(3'd2, '0);
        checkState("pop1", 3, 32'h33, 32'h22, 32'h44, 0, 0);
        applyStimulus(3'd2, '0);
        checkState("pop2", 2, 32'h22, 32'h11, 32'h33, 0, 0);
        applyStimulus(3'd2, '0);
        checkState("pop3", 1, 32'h11, 0, 32'h22, 0, 0);
        applyStimulus(3'd2, '0);
        checkState("pop4", 0, 0, 0, 32'h11, 0, 0);
        applyStimulus(3'd2, '0);
        checkState("pop_unf", 0, 0, 0, 32'h11, 0, 1);
        applyStimulus(3'd0, '0);
        checkState("unf_clear", 0, 0, 0, 32'h11, 0, 0);

        applyStimulus(3'd1, 32'hA);
        applyStimulus(3'd1, 32'hB);
        applyStimulus(3'd5, '0);
        checkState("swap", 2, 32'hA, 32'hB, 32'h11, 0, 0);
        applyStimulus(3'd4, '0);
        checkState("dup", 3, 32'hA, 32'hA, 32'h11, 0, 0);
        applyStimulus(3'd2, '0);
        applyStimulus(3'd2, '0);
        checkState("pop_to_one", 1, 32'hB, 0, 32'hA, 0, 0);
        applyStimulus(3'd5, '0);
        checkState("swap_unf", 1, 32'hB, 0, 32'hA, 0, 1);
        applyStimulus(3'd2, '0);
        checkState("pop_b", 0, 0, 0, 32'hB, 0, 0);

        applyStimulus(3'd1, 32'h5);
        applyStimulus(3'd3, 32'h9);
        checkState("replace", 1, 32'h9, 0, 32'h5, 0, 0);
        applyStimulus(3'd2, '0);
        checkState("pop_9", 0, 0, 0, 32'h9, 0, 0);
        applyStimulus(3'd3, 32'h7);
        checkState("replace_empty", 1, 32'h7, 0, 32'h9, 0, 0);
        applyStimulus(3'd2, '0);
        applyStimulus(3'd4, '0);
        checkState("dup_unf", 0, 0, 0, 32'h7, 0, 1);

        for (int i = 1; i <= 4; i++) applyStimulus(3'd1, DW'(i));
        applyStimulus(3'd4, '0);
        checkState("dup_ovf", 4, 32'h4, 32'h3, 32'h7, 1, 0);
        applyStimulus(3'd2, '0);
        checkState("pop_from_full", 3, 32'h3, 32'h2, 32'h4, 0, 0);

        reset = 1'b1;
        applyStimulus(3'd1, 32'hDEAD);
        reset = 1'b0;
        checkState("reset_mid", 0, 0, 0, 0, 0, 0);

        applyStimulus(3'd1, 32'h66);
        applyStimulus(3'd1, 32'h77);
        applyStimulus(3'd6, 32'h99);
        checkState("op6", 2, 32'h77, 32'h66, 0, 0, 0);
        applyStimulus(3'd7, 32'h99);
        checkState("op7", 2, 32'h77, 32'h66, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
